// File: rtl/bus_cycle_sequencer.sv
// Instruction-cycle sequencer for the multiplexed nibble bus: subcycle counter,
// address/register drive, ROM/RAM strobes, instruction capture and wait states.
module bus_cycle_sequencer #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_NIBBLES = 3,
    parameter int INST_NIBBLES = 2,
    parameter int EXEC_CYCLES  = 3,
    parameter int NUM_RAM_CMD  = 4,
    parameter int STALL_MAX    = 7,
    localparam int AW = DATA_WIDTH * ADDR_NIBBLES,
    localparam int IW = DATA_WIDTH * INST_NIBBLES,
    localparam int N  = ADDR_NIBBLES + INST_NIBBLES + EXEC_CYCLES,
    localparam int CW = $clog2(N)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [AW-1:0]          pc,
    input  logic                   stall,
    input  logic [NUM_RAM_CMD-1:0] ram_cmd_mask,
    input  logic                   io_cycle,
    input  logic                   reg_out_enable,
    input  logic [DATA_WIDTH-1:0]  regval,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_oe,
    output logic [CW-1:0]          cycle,
    output logic                   sync,
    output logic                   rom_cmd,
    output logic [NUM_RAM_CMD-1:0] ram_cmd,
    output logic [IW-1:0]          inst,
    output logic                   inst_valid,
    output logic                   stall_timeout
);

    localparam logic [CW-1:0] LAST_ADDR = CW'(ADDR_NIBBLES - 1);
    localparam logic [CW-1:0] FIRST_F   = CW'(ADDR_NIBBLES);
    localparam logic [CW-1:0] LAST_F    = CW'(ADDR_NIBBLES + INST_NIBBLES - 1);
    localparam logic [CW-1:0] X2        = CW'(ADDR_NIBBLES + INST_NIBBLES + 1);
    localparam logic [CW-1:0] LAST      = CW'(N - 1);
    localparam int            SCW       = $clog2(STALL_MAX + 1);

    logic [AW-1:0]  pc_q;
    logic [SCW-1:0] stall_cnt;
    logic           in_fetch;
    logic           stall_hold;
    logic           stall_force;

    always_comb begin
        in_fetch    = (cycle >= FIRST_F) && (cycle <= LAST_F);
        stall_hold  = in_fetch && stall && (stall_cnt < SCW'(STALL_MAX - 1));
        stall_force = in_fetch && stall && !stall_hold;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle         <= '0;
            pc_q          <= '0;
            inst          <= '0;
            inst_valid    <= 1'b0;
            stall_timeout <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            inst_valid <= 1'b0;
            if (stall_hold) begin
                stall_cnt <= stall_cnt + SCW'(1);
            end else begin
                stall_cnt <= '0;
                cycle     <= (cycle == LAST) ? '0 : cycle + CW'(1);
                if (cycle == LAST)
                    pc_q <= pc;
                if (in_fetch) begin
                    // first fetched nibble lands in the most significant position
                    for (int unsigned j = 0; j < INST_NIBBLES; j++)
                        if (cycle == CW'(ADDR_NIBBLES + j))
                            inst[(INST_NIBBLES-1-j)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                    if (cycle == LAST_F)
                        inst_valid <= 1'b1;
                end
            end
            if (stall_force)
                stall_timeout <= 1'b1;
        end
    end

    // Bus and strobes are decoded from the counter; held inactive while reset is asserted.
    always_comb begin
        data_oe  = 1'b0;
        data_out = '0;
        sync     = 1'b0;
        rom_cmd  = 1'b1;
        ram_cmd  = '1;
        if (reset) begin
            sync = (cycle == LAST);
            for (int unsigned k = 0; k < ADDR_NIBBLES; k++) begin
                if (cycle == CW'(k)) begin
                    data_oe  = 1'b1;
                    data_out = pc_q[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if ((cycle == X2) && reg_out_enable) begin
                data_oe  = 1'b1;
                data_out = regval;
            end
            if ((cycle == LAST_ADDR) || ((cycle == X2) && io_cycle)) begin
                rom_cmd = 1'b0;
                ram_cmd = ~ram_cmd_mask;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Randomised scoreboard bench for bus_cycle_sequencer: default build plus a
// four-address-nibble, eight-RAM-line build sharing the same clock and reset.
module tb_bus_cycle_sequencer;

    localparam int A = 3, I = 2, N = 8, X2 = 6, SMAX = 7;
    localparam int A2 = 4, N2 = 9;

    typedef struct {
        logic [2:0]  cyc;
        logic        sync, rom, oe, iv, tmo;
        logic [3:0]  ram, dout;
        logic [7:0]  inst;
        logic [3:0]  cyc2;
        logic        sync2, rom2, oe2, iv2;
        logic [7:0]  ram2, inst2;
        logic [3:0]  dout2;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] pc = '0;
    logic        stall = 1'b0;
    logic [3:0]  mask = '0;
    logic        io = 1'b0, reo = 1'b0;
    logic [3:0]  regval = '0, din = '0;
    logic [15:0] pc2 = '0;
    logic [7:0]  mask2 = 8'hA5;

    logic [3:0]  dout;
    logic        oe, sync, rom, iv, tmo;
    logic [2:0]  cyc;
    logic [3:0]  ram;
    logic [7:0]  inst;

    logic [3:0]  dout2, cyc2;
    logic        oe2, sync2, rom2, iv2, tmo2;
    logic [7:0]  ram2, inst2;

    int checks = 0;
    int failures = 0;

    // reference model state
    int unsigned pos = 0, run = 0, pos2 = 0;
    bit          tmo_m = 0, iv_m = 0, iv2_m = 0;
    logic [11:0] addr = '0;
    logic [15:0] addr2 = '0;
    logic [7:0]  inst_m = '0, inst2_m = '0;
    logic [7:0]  inst_q[$];
    exp_t        exp_q[$];

    bus_cycle_sequencer dut (
        .clock(clock), .reset(reset), .pc(pc), .stall(stall),
        .ram_cmd_mask(mask), .io_cycle(io), .reg_out_enable(reo), .regval(regval),
        .data_in(din), .data_out(dout), .data_oe(oe), .cycle(cyc), .sync(sync),
        .rom_cmd(rom), .ram_cmd(ram), .inst(inst), .inst_valid(iv), .stall_timeout(tmo)
    );

    bus_cycle_sequencer #(.ADDR_NIBBLES(4), .NUM_RAM_CMD(8)) dut2 (
        .clock(clock), .reset(reset), .pc(pc2), .stall(1'b0),
        .ram_cmd_mask(mask2), .io_cycle(1'b0), .reg_out_enable(1'b0), .regval(regval),
        .data_in(din), .data_out(dout2), .data_oe(oe2), .cycle(cyc2), .sync(sync2),
        .rom_cmd(rom2), .ram_cmd(ram2), .inst(inst2), .inst_valid(iv2), .stall_timeout(tmo2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; run = 0; tmo_m = 0; iv_m = 0; addr = '0; inst_m = '0;
        pos2 = 0; addr2 = '0; inst2_m = '0; iv2_m = 0;
        inst_q.delete();
    endtask

    // Applies one rising edge to the model using the inputs held through that edge.
    task automatic model_edge();
        bit adv;
        int j;
        if (!reset) return;
        iv_m = 0;
        adv  = 1;
        if (pos >= A && pos < A + I) begin
            j = int'(pos) - A;
            if (stall) begin
                run++;
                if (run < SMAX) adv = 0;
                else tmo_m = 1;
            end
            if (adv) begin
                inst_m[(I-1-j)*4 +: 4] = din;
                if (j == I - 1) begin
                    iv_m = 1;
                    inst_q.push_back(inst_m);
                end
            end
        end
        if (adv) begin
            run = 0;
            pos = (pos + 1) % N;
            if (pos == 0) addr = pc;
        end
        iv2_m = (pos2 == 5);
        if (pos2 == 4) inst2_m[7:4] = din;
        if (pos2 == 5) inst2_m[3:0] = din;
        pos2 = (pos2 + 1) % N2;
        if (pos2 == 0) addr2 = pc2;
    endtask

    task automatic push_expect();
        exp_t e;
        bit   strobe;
        if (!reset) begin
            e.cyc = '0; e.sync = 0; e.rom = 1; e.oe = 0; e.iv = 0; e.tmo = 0;
            e.ram = 4'hF; e.dout = '0; e.inst = '0;
            e.cyc2 = '0; e.sync2 = 0; e.rom2 = 1; e.oe2 = 0; e.iv2 = 0;
            e.ram2 = 8'hFF; e.inst2 = '0; e.dout2 = '0;
        end else begin
            e.cyc  = 3'(pos);
            e.sync = (pos == N - 1);
            strobe = (pos == A - 1) || (pos == X2 && io);
            e.rom  = !strobe;
            e.ram  = strobe ? ~mask : 4'hF;
            e.oe   = 0;
            e.dout = '0;
            if (pos < A) begin
                e.oe = 1; e.dout = 4'(addr >> (4 * pos));
            end else if (pos == X2 && reo) begin
                e.oe = 1; e.dout = regval;
            end
            e.iv = iv_m; e.tmo = tmo_m; e.inst = inst_m;
            e.cyc2  = 4'(pos2);
            e.sync2 = (pos2 == N2 - 1);
            e.rom2  = (pos2 != A2 - 1);
            e.ram2  = (pos2 == A2 - 1) ? ~mask2 : 8'hFF;
            e.oe2   = (pos2 < A2);
            e.dout2 = (pos2 < A2) ? 4'(addr2 >> (4 * pos2)) : 4'h0;
            e.iv2   = iv2_m;
            e.inst2 = inst2_m;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input int unsigned stall_pct, input bit force_stall,
                        input bit do_reset, input bit fixed);
        @(posedge clock);
        model_edge();
        #2;
        din = 4'($urandom);
        pc2 = 16'($urandom);
        if (fixed) begin
            pc = 12'hA53; mask = 4'b0101; io = 1; reo = 1; regval = 4'h9;
        end else begin
            pc = 12'($urandom); mask = 4'($urandom); io = 1'($urandom);
            reo = 1'($urandom); regval = 4'($urandom);
        end
        stall = force_stall ? 1'b1 : ($urandom_range(99) < stall_pct);
        if (do_reset) begin
            reset = 1'b0;
            model_reset();
        end else begin
            reset = 1'b1;
        end
        push_expect();
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cycle", cyc, e.cyc);
            chk("sync", sync, e.sync);
            chk("rom_cmd", rom, e.rom);
            chk("ram_cmd", ram, e.ram);
            chk("data_oe", oe, e.oe);
            chk("data_out", dout, e.dout);
            chk("inst_valid", iv, e.iv);
            chk("inst", inst, e.inst);
            chk("stall_timeout", tmo, e.tmo);
            chk("cycle2", cyc2, e.cyc2);
            chk("sync2", sync2, e.sync2);
            chk("rom_cmd2", rom2, e.rom2);
            chk("ram_cmd2", ram2, e.ram2);
            chk("data_oe2", oe2, e.oe2);
            chk("data_out2", dout2, e.dout2);
            chk("inst_valid2", iv2, e.iv2);
            chk("inst2", inst2, e.inst2);
            chk("stall_timeout2", tmo2, 0);
        end
        if (iv === 1'b1) begin
            if (inst_q.size() == 0) chk("inst_valid_spurious", iv, 0);
            else chk("inst_scoreboard", inst, inst_q.pop_front());
        end
    end

    initial begin
        repeat (3) step(0, 0, 1, 0);
        repeat (20) step(0, 0, 0, 1);
        repeat (300) step(25, 0, 0, 0);
        // two wait states in the first fetch subcycle
        for (int k = 0; k < N + 1 && pos != 2; k++) step(0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        // reset asserted while in subcycle 4
        for (int k = 0; k < N + 1 && pos != 3; k++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (12) step(0, 0, 0, 0);
        // stall held through the second fetch subcycle long enough to time out
        for (int k = 0; k < N + 1 && pos != 3; k++) step(0, 0, 0, 0);
        repeat (10) step(0, 1, 0, 0);
        repeat (60) step(30, 0, 0, 0);
        @(negedge clock);
        #1;
        chk("inst_q_drain", inst_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
